mul_pipe_hs: RTL and testbench

//   Parametrised pipelined integer multiplier with valid/ready handshake on both sides.

---
 rtl/mul_pipe_hs.sv | 106 ++++++++++
 tb/tb_mul_pipe_hs.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe_hs.sv
// mul_pipe_hs: pipelined DWIDTH x DWIDTH multiplier with valid/ready handshake and tag passthrough.
// Define MUL_PIPE_OPCNT_EN to build the completed-operation counter driven on op_cnt_o.
module mul_pipe_hs #(
    parameter int unsigned DWIDTH = 11,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAGW   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DWIDTH-1:0]     a_i,
    input  logic [DWIDTH-1:0]     b_i,
    input  logic                  signed_i,
    input  logic [TAGW-1:0]       tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [2*DWIDTH-1:0]   res_o,
    output logic [TAGW-1:0]       tag_o,
    output logic [31:0]           op_cnt_o
);

    localparam int unsigned PW = 2 * DWIDTH;

    logic              en;

    // Operand stage: the multiply is formed combinationally from these registers.
    logic              s0_valid_q;
    logic [DWIDTH-1:0] s0_a_q;
    logic [DWIDTH-1:0] s0_b_q;
    logic              s0_signed_q;
    logic [TAGW-1:0]   s0_tag_q;

    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     b_ext;
    logic [PW-1:0]     prod;

    // Product delay stages; the last one drives the outputs.
    logic [STAGES-1:0] vld_q;
    logic [PW-1:0]     prod_q [STAGES];
    logic [TAGW-1:0]   tag_q  [STAGES];

    assign en         = ~out_valid_o | out_ready_i;
    assign in_ready_o = en;

    always_comb begin
        a_ext = s0_signed_q ? {{DWIDTH{s0_a_q[DWIDTH-1]}}, s0_a_q} : {{DWIDTH{1'b0}}, s0_a_q};
        b_ext = s0_signed_q ? {{DWIDTH{s0_b_q[DWIDTH-1]}}, s0_b_q} : {{DWIDTH{1'b0}}, s0_b_q};
        prod  = a_ext * b_ext;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s0_valid_q  <= 1'b0;
            s0_a_q      <= '0;
            s0_b_q      <= '0;
            s0_signed_q <= 1'b0;
            s0_tag_q    <= '0;
            vld_q       <= '0;
            for (int k = 0; k < STAGES; k++) begin
                prod_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else if (en) begin
            s0_valid_q <= in_valid_i;
            // Data captured only with a real beat so idle-bus X never enters the pipe.
            if (in_valid_i) begin
                s0_a_q      <= a_i;
                s0_b_q      <= b_i;
                s0_signed_q <= signed_i;
                s0_tag_q    <= tag_i;
            end
            vld_q[0] <= s0_valid_q;
            if (s0_valid_q) begin
                prod_q[0] <= prod;
                tag_q[0]  <= s0_tag_q;
            end
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k]  <= vld_q[k-1];
                prod_q[k] <= prod_q[k-1];
                tag_q[k]  <= tag_q[k-1];
            end
        end
    end

    assign out_valid_o = vld_q[STAGES-1];
    assign res_o       = prod_q[STAGES-1];
    assign tag_o       = tag_q[STAGES-1];

`ifdef MUL_PIPE_OPCNT_EN
    logic [31:0] op_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_cnt_q <= '0;
        end else if (out_valid_o && out_ready_i) begin
            op_cnt_q <= op_cnt_q + 32'd1;
        end
    end

    assign op_cnt_o = op_cnt_q;
`else
    assign op_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mul_pipe_hs.sv
// tb_mul_pipe_hs: directed and random checks of mul_pipe_hs against an arithmetic reference model.
module tb_mul_pipe_hs;

    localparam int DW = 11;
    localparam int ST = 3;
    localparam int TW = 4;
    localparam int PW = 2 * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, sgn;
    logic [DW-1:0] a, b;
    logic [TW-1:0] tag, tag_out;
    logic [PW-1:0] res;
    logic [31:0]   op_cnt;

    logic          in_valid1, in_ready1, out_valid1, sgn1;
    logic [DW-1:0] a1, b1;
    logic [TW-1:0] tag1, tag_out1;
    logic [PW-1:0] res1;
    logic [31:0]   op_cnt1;

    mul_pipe_hs #(.DWIDTH(DW), .STAGES(ST), .TAGW(TW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .signed_i(sgn), .tag_i(tag), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .res_o(res), .tag_o(tag_out), .op_cnt_o(op_cnt)
    );

    mul_pipe_hs #(.DWIDTH(DW), .STAGES(1), .TAGW(TW)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .a_i(a1), .b_i(b1), .signed_i(sgn1), .tag_i(tag1), .out_valid_o(out_valid1),
        .out_ready_i(1'b1), .res_o(res1), .tag_o(tag_out1), .op_cnt_o(op_cnt1)
    );

    typedef struct {
        logic [PW-1:0] res;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;

    function automatic logic [PW-1:0] model(logic [DW-1:0] x, logic [DW-1:0] y, logic s);
        longint xv, yv, p;
        xv = longint'(x);
        yv = longint'(y);
        if (s && x[DW-1]) xv = xv - (longint'(1) << DW);
        if (s && y[DW-1]) yv = yv - (longint'(1) << DW);
        p = xv * yv;
        return p[PW-1:0];
    endfunction

    task automatic check(string name, logic [31:0] obs, logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, want);
        end
    endtask

    // One clock: account handshakes at the falling edge, return #1 after the rising edge.
    task automatic tick(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = rst_n && in_valid && in_ready;
        if (acc) exp_q.push_back('{model(a, b, sgn), tag});
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL spurious_out: observed res %0h with no beat outstanding", res);
            end else begin
                e = exp_q.pop_front();
                check("res", 32'(res), 32'(e.res));
                check("tag", 32'(tag_out), 32'(e.tag));
                n_done++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic single(string nm, logic [DW-1:0] ai, logic [DW-1:0] bi, logic s,
                          logic [TW-1:0] ti, logic [PW-1:0] want);
        int lat;
        bit acc;
        a = ai; b = bi; sgn = s; tag = ti; in_valid = 1'b1; out_ready = 1'b1;
        tick(acc);
        check({nm, "_accept"}, 32'(acc), 32'd1);
        in_valid = 1'b0; a = 'x; b = 'x;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick(acc);
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(ST));
        check({nm, "_res"}, 32'(res), 32'(want));
        check({nm, "_tag"}, 32'(tag_out), 32'(ti));
        tick(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int i, t;
        logic [31:0] want_cnt;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sgn = 1'b0; tag = '0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; sgn1 = 1'b0; tag1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_tag", 32'(tag_out), 32'd0);
        check("rst_op_cnt", op_cnt, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Reset with two beats in flight: neither may ever emerge.
        in_valid = 1'b1; a = 11'd7; b = 11'd9; tag = 4'd1;
        tick(acc);
        a = 11'd8; tag = 4'd2;
        tick(acc);
        in_valid = 1'b0; rst_n = 1'b0;
        tick(acc);
        exp_q.delete();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("flush_out_valid", 32'(out_valid), 32'd0);
            tick(acc);
        end
        check("flush_op_cnt", op_cnt, 32'd0);

        single("unsigned_max", 11'd2047, 11'd2047, 1'b0, 4'd5, 22'h3FF001);
        single("signed_minpos", 11'h400, 11'd1023, 1'b1, 4'd6, 22'h300400);
        single("signed_m1m1", 11'h7FF, 11'h7FF, 1'b1, 4'd7, 22'h000001);

        // Back-pressure: consumer stalls for 4 cycles mid-stream.
        n_done = 0; i = 0; t = 0;
        while (n_done < 8 && t < 60) begin
            in_valid = (i < 8); a = DW'(i); b = 11'd3; sgn = 1'b0; tag = TW'(i);
            out_ready = !(t >= 4 && t < 8);
            #1;
            if (t >= 4 && t < 8) begin
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
            tick(acc);
            if (acc) i++;
            t++;
        end
        check("bp_done", 32'(n_done), 32'd8);
        check("bp_leftover", 32'(exp_q.size()), 32'd0);

        // Full rate from a clean pipe: 100 random beats.
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
        tick(acc);
        rst_n = 1'b1; exp_q.delete(); n_done = 0;
        for (int k = 0; k < 110; k++) begin
            in_valid = (k < 100);
            a = DW'($urandom); b = DW'($urandom);
            sgn = 1'($urandom_range(0, 1)); tag = TW'($urandom);
            #1;
            check("full_in_ready", 32'(in_ready), 32'd1);
            check("full_out_valid", 32'(out_valid), 32'((k >= 4) && (k < 104)));
            tick(acc);
        end
        check("full_done", 32'(n_done), 32'd100);
`ifdef MUL_PIPE_OPCNT_EN
        want_cnt = 32'd100;
`else
        want_cnt = 32'd0;
`endif
        check("full_op_cnt", op_cnt, want_cnt);

        // Single-stage instance: result one cycle after acceptance.
        in_valid = 1'b0;
        a1 = 11'd3; b1 = 11'd5; sgn1 = 1'b0; tag1 = 4'd9; in_valid1 = 1'b1;
        #1;
        check("s1_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        check("s1_early", 32'(out_valid1), 32'd0);
        @(posedge clk);
        #1;
        check("s1_out_valid", 32'(out_valid1), 32'd1);
        check("s1_res", 32'(res1), 32'd15);
        check("s1_tag", 32'(tag_out1), 32'd9);
        @(posedge clk);
        #1;
        check("s1_drained", 32'(out_valid1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
